// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and default 640x480@60 timing for the VGA scan-out
package vga_pkg;

    typedef logic [2:0]  pixel_t;
    typedef logic [16:0] fb_addr_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_FB_WIDTH = 320;
    localparam int DEF_CLK_DIV  = 2;

    localparam int FB_SIZE = 76800;

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel-tick divider, h/v counters, raw syncs and frame strobe
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   tick                high on the clock whose edge advances the pixel counters
//   h_active, v_active  current h / v inside the visible range
//   visible             h_active && v_active
//   h_odd, v_odd        low bits of the current h / v
//   line_end, frame_end current pixel is the last of its line / frame
//   hsync_raw, vsync_raw active-high syncs decoded from the current counters
//   frame_start         one-clock pulse after the counters wrap to (0,0)
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic clock,
    input  logic reset,
    output logic tick,
    output logic h_active,
    output logic v_active,
    output logic visible,
    output logic h_odd,
    output logic v_odd,
    output logic line_end,
    output logic frame_end,
    output logic hsync_raw,
    output logic vsync_raw,
    output logic frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
    localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
    localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [9:0]    h;
    logic [9:0]    v;

    // The counters hold the pixel that becomes current on the next tick, so
    // after reset the first tick issues (0,0) without a wrap and no strobe.
    assign tick      = (div == DIV_LAST);
    assign h_active  = (h < H_ACT);
    assign v_active  = (v < V_ACT);
    assign visible   = h_active && v_active;
    assign h_odd     = h[0];
    assign v_odd     = v[0];
    assign line_end  = (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);
    assign hsync_raw = (h >= HS_BEG) && (h < HS_END);
    assign vsync_raw = (v >= VS_BEG) && (v < VS_END);

    always_ff @(posedge clock) begin
        if (reset) begin
            div         <= '0;
            h           <= '0;
            v           <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= tick && frame_end;
            if (tick) begin
                div <= '0;
                if (line_end) begin
                    h <= '0;
                    v <= frame_end ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 640x480 VGA scan-out of a pixel-doubled 320x240 3-bit frame buffer
// Ports:
//   clock, reset             system clock, synchronous active-high reset
//   addr_B                   frame-buffer port B read address
//   dataOut_B                port B read data, one clock after addr_B
//   vga_r, vga_g, vga_b      colour bits (pixel bit 2/1/0)
//   hsync_n, vsync_n         active-low syncs, aligned with RGB
//   blank_n                  high while RGB carries a visible pixel
//   frame_start              one-clock pulse when the raster wraps to (0,0)
module vga_scanout
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int FB_WIDTH = DEF_FB_WIDTH,
    parameter int CLK_DIV  = DEF_CLK_DIV
) (
    input  logic     clock,
    input  logic     reset,
    output fb_addr_t addr_B,
    input  pixel_t   dataOut_B,
    output logic     vga_r,
    output logic     vga_g,
    output logic     vga_b,
    output logic     hsync_n,
    output logic     vsync_n,
    output logic     blank_n,
    output logic     frame_start
);

    localparam fb_addr_t ROW_STEP = fb_addr_t'(FB_WIDTH);

    logic tick, h_active, v_active, visible, h_odd, v_odd;
    logic line_end, frame_end, hsync_raw, vsync_raw;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .h_active    (h_active),
        .v_active    (v_active),
        .visible     (visible),
        .h_odd       (h_odd),
        .v_odd       (v_odd),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .frame_start (frame_start)
    );

    fb_addr_t line_base;
    fb_addr_t x_off;
    logic     vis_d, hs_d, vs_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_B    <= '0;
            line_base <= '0;
            x_off     <= '0;
            vis_d     <= 1'b0;
            hs_d      <= 1'b0;
            vs_d      <= 1'b0;
            vga_r     <= 1'b0;
            vga_g     <= 1'b0;
            vga_b     <= 1'b0;
            blank_n   <= 1'b0;
            hsync_n   <= 1'b1;
            vsync_n   <= 1'b1;
        end else if (tick) begin
            // Address stage: only visible pixels load a new address, so the
            // bus parks on the last one read during blanking.
            if (visible)
                addr_B <= line_base + x_off;
            // Each frame-buffer column is shown twice, so step after odd h.
            if (line_end)
                x_off <= '0;
            else if (h_active && h_odd)
                x_off <= x_off + fb_addr_t'(1);
            // Each frame-buffer row is shown twice, so step after odd lines.
            if (frame_end)
                line_base <= '0;
            else if (line_end && v_active && v_odd)
                line_base <= line_base + ROW_STEP;
            vis_d <= visible;
            hs_d  <= hsync_raw;
            vs_d  <= vsync_raw;
            // Output stage: read data for the previous tick's address has
            // been stable for CLK_DIV-1 clocks by now.
            {vga_r, vga_g, vga_b} <= vis_d ? dataOut_B : 3'b000;
            blank_n <= vis_d;
            hsync_n <= ~hs_d;
            vsync_n <= ~vs_d;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - scoreboard and probe-table bench for vga_scanout
module tb_vga_scanout;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    wire  [1:0][16:0] addr_b;
    logic [1:0][2:0]  dout;
    wire  [1:0]       r, g, b, hs_n, vs_n, bl_n, fs;

    // Instance 0: default 640x480 timing. Instance 1: tiny raster for frame-level checks.
    vga_scanout u_full (
        .clock(clock), .reset(reset), .addr_B(addr_b[0]), .dataOut_B(dout[0]),
        .vga_r(r[0]), .vga_g(g[0]), .vga_b(b[0]), .hsync_n(hs_n[0]),
        .vsync_n(vs_n[0]), .blank_n(bl_n[0]), .frame_start(fs[0])
    );

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .FB_WIDTH(8), .CLK_DIV(2)
    ) u_small (
        .clock(clock), .reset(reset), .addr_B(addr_b[1]), .dataOut_B(dout[1]),
        .vga_r(r[1]), .vga_g(g[1]), .vga_b(b[1]), .hsync_n(hs_n[1]),
        .vsync_n(vs_n[1]), .blank_n(bl_n[1]), .frame_start(fs[1])
    );

    // Frame-buffer model: data = addr[2:0], one clock of latency.
    always @(posedge clock) begin
        dout[0] <= addr_b[0][2:0];
        dout[1] <= addr_b[1][2:0];
    end

    typedef struct { int ha, hf, hs, hb, va, vf, vs, vb, fbw; } tim_t;
    typedef struct { bit vis; int addr; bit hs_low; bit vs_low; bit last; } pix_t;
    typedef struct packed { logic [2:0] rgb; logic blank_n; logic hsync_n; logic vsync_n; } outrec_t;
    typedef struct { int cyc; int addr; logic hsync_n; logic blank_n; } probe_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit armed = 1'b0;
    bit rst_q = 1'b1;

    always @(posedge clock) begin
        armed <= 1'b1;
        rst_q <= reset;
        cyc   <= reset ? 0 : cyc + 1;
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d cyc=%0d got=%0d want=%0d", name, inst, cyc, act, exp);
        end
    endtask

    function automatic tim_t tim(input int i);
        tim_t t;
        if (i == 0) t = '{640, 16, 96, 48, 480, 10, 2, 33, 320};
        else        t = '{16, 2, 3, 3, 8, 2, 2, 2, 8};
        return t;
    endfunction

    // Reference pixel p (0-based tick count since reset release) by direct arithmetic.
    function automatic pix_t model(input int i, input int p);
        tim_t t;
        pix_t e;
        int ht, vt, h, v;
        t  = tim(i);
        ht = t.ha + t.hf + t.hs + t.hb;
        vt = t.va + t.vf + t.vs + t.vb;
        h  = p % ht;
        v  = (p / ht) % vt;
        e.vis    = (h < t.ha) && (v < t.va);
        e.addr   = (v / 2) * t.fbw + h / 2;
        e.hs_low = (h >= t.ha + t.hf) && (h < t.ha + t.hf + t.hs);
        e.vs_low = (v >= t.va + t.vf) && (v < t.va + t.vf + t.vs);
        e.last   = (h == ht - 1) && (v == vt - 1);
        return e;
    endfunction

    outrec_t sb0[$];
    outrec_t sb1[$];
    outrec_t cur[2];
    int      last_addr[2];

    always @(negedge clock) begin : scoreboard
        pix_t    e;
        outrec_t o;
        bit      exp_fs;
        int      p;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                exp_fs = 1'b0;
                if (rst_q) begin
                    o = '{3'b000, 1'b0, 1'b1, 1'b1};
                    if (i == 0) begin sb0.delete(); sb0.push_back(o); end
                    else        begin sb1.delete(); sb1.push_back(o); end
                    cur[i]       = o;
                    last_addr[i] = 0;
                end else if (cyc % 2 == 0) begin
                    p = cyc / 2 - 1;
                    e = model(i, p);
                    if (e.vis) last_addr[i] = e.addr;
                    exp_fs    = e.last;
                    o.rgb     = e.vis ? 3'(e.addr % 8) : 3'b000;
                    o.blank_n = e.vis;
                    o.hsync_n = !e.hs_low;
                    o.vsync_n = !e.vs_low;
                    if (i == 0) begin cur[0] = sb0.pop_front(); sb0.push_back(o); end
                    else        begin cur[1] = sb1.pop_front(); sb1.push_back(o); end
                end
                chk("addr_B",      i, 32'(addr_b[i]),       32'(last_addr[i]));
                chk("rgb",         i, {29'd0, r[i], g[i], b[i]}, 32'(cur[i].rgb));
                chk("blank_n",     i, 32'(bl_n[i]),         32'(cur[i].blank_n));
                chk("hsync_n",     i, 32'(hs_n[i]),         32'(cur[i].hsync_n));
                chk("vsync_n",     i, 32'(vs_n[i]),         32'(cur[i].vsync_n));
                chk("frame_start", i, 32'(fs[i]),           32'(exp_fs));
            end
        end
    end

    task automatic wait_cyc(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 20000) begin
            @(negedge clock);
            guard++;
        end
        chk("wait_cyc", -1, cyc, target);
    endtask

    probe_t tv[16];
    int     pulses;

    initial begin : main
        // {clocks after release, addr_B, hsync_n, blank_n} for the default raster
        tv[0]  = '{1,    0,   1'b1, 1'b0};
        tv[1]  = '{2,    0,   1'b1, 1'b0};
        tv[2]  = '{4,    0,   1'b1, 1'b1};
        tv[3]  = '{6,    1,   1'b1, 1'b1};
        tv[4]  = '{8,    1,   1'b1, 1'b1};
        tv[5]  = '{1280, 319, 1'b1, 1'b1};
        tv[6]  = '{1282, 319, 1'b1, 1'b1};
        tv[7]  = '{1284, 319, 1'b1, 1'b0};
        tv[8]  = '{1314, 319, 1'b1, 1'b0};
        tv[9]  = '{1316, 319, 1'b0, 1'b0};
        tv[10] = '{1506, 319, 1'b0, 1'b0};
        tv[11] = '{1508, 319, 1'b1, 1'b0};
        tv[12] = '{1602, 0,   1'b1, 1'b0};
        tv[13] = '{1604, 0,   1'b1, 1'b1};
        tv[14] = '{3202, 320, 1'b1, 1'b0};
        tv[15] = '{3206, 321, 1'b1, 1'b1};

        reset = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            wait_cyc(tv[k].cyc);
            chk("probe_addr",    0, 32'(addr_b[0]), 32'(tv[k].addr));
            chk("probe_hsync_n", 0, 32'(hs_n[0]),   32'(tv[k].hsync_n));
            chk("probe_blank_n", 0, 32'(bl_n[0]),   32'(tv[k].blank_n));
        end

        // Mid-frame reset: small raster sits at v=5, h=7 here.
        wait_cyc(5632);
        chk("pre_reset_addr",    1, 32'(addr_b[1]), 32'd19);
        chk("pre_reset_blank_n", 1, 32'(bl_n[1]),   32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_reset_addr",    1, 32'(addr_b[1]), 32'd0);
        chk("mid_reset_blank_n", 1, 32'(bl_n[1]),   32'd0);
        chk("mid_reset_hsync_n", 0, 32'(hs_n[0]),   32'd1);

        // Small raster: one frame is 336 ticks, wrap strobe after tick 336.
        pulses = 0;
        while (cyc < 671 && pulses < 10) begin
            @(negedge clock);
            pulses += int'(fs[1]);
        end
        chk("no_early_frame_start", 1, pulses, 0);
        @(negedge clock);
        chk("frame_start_pulse", 1, 32'(fs[1]),     32'd1);
        chk("last_visible_addr", 1, 32'(addr_b[1]), 32'd31);
        @(negedge clock);
        chk("frame_start_width", 1, 32'(fs[1]),     32'd0);
        @(negedge clock);
        chk("wrap_addr",         1, 32'(addr_b[1]), 32'd0);

        wait_cyc(4000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
